// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM state encoding,
// register-address width and default stall/flush lengths.
package hazard_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int LOAD_STALL_DEF   = 1;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hzState_t;

endpackage

// File: rtl/hazard_compare.sv
// Load-use comparator: flags a loaded EX destination that the ID instruction reads.
// x0 is filtered out so the same block can serve x0-aware forwarding compares.
module hazard_compare
  import hazard_pkg::*;
(
  input  logic                  memRead,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  usesRs2,
  output logic                  hit
);

  // Hazard match against rs1 always, against rs2 only when it is really read.
  always_comb begin
    hit = memRead && (rd != {REG_ADDR_W{1'b0}}) &&
          ((rd == rs1) || (usesRs2 && (rd == rs2)));
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / taken-branch hazard controller driving PC, IF/ID and bubble-mux controls.
// Optional perf counters (stall_count, flush_count) built when HAZARD_PERF_CNT_EN is defined.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL   = LOAD_STALL_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_MemRead,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  ctrl_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  // Counter preloads: the detecting cycle is itself the first bubble.
  localparam logic [1:0] STALL_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;
  localparam logic [1:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
  localparam hzState_t   STALL_NEXT = (LOAD_STALL > 1) ? HZ_STALL : HZ_RUN;
  localparam hzState_t   FLUSH_NEXT = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;

  hzState_t   stateR, stateNxt;
  logic [1:0] cntR, cntNxt;
  logic       luh;

  hazard_compare uCompare (
    .memRead (ex_MemRead),
    .rd      (ex_rd),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .usesRs2 (id_uses_rs2),
    .hit     (luh)
  );

  // State and remaining-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= HZ_RUN;
      cntR   <= 2'd0;
    end else begin
      stateR <= stateNxt;
      cntR   <= cntNxt;
    end
  end

  // Next-state and output decode; a branch overrides everything except reset.
  always_comb begin
    stateNxt   = stateR;
    cntNxt     = cntR;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    ctrl_sel   = 1'b1;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      ctrl_sel   = 1'b0;
      stateNxt   = HZ_RUN;
      cntNxt     = 2'd0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      ctrl_sel   = 1'b0;
      stateNxt   = FLUSH_NEXT;
      cntNxt     = FLUSH_INIT;
    end else begin
      case (stateR)
        HZ_RUN: begin
          if (luh) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_sel   = 1'b0;
            stateNxt   = STALL_NEXT;
            cntNxt     = STALL_INIT;
          end else begin
            stateNxt = HZ_RUN;
          end
        end
        HZ_STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ctrl_sel   = 1'b0;
          if (cntR == 2'd0) begin
            stateNxt = HZ_RUN;
          end else begin
            cntNxt = cntR - 2'd1;
          end
        end
        HZ_FLUSH: begin
          ifid_flush = 1'b1;
          ctrl_sel   = 1'b0;
          if (cntR == 2'd0) begin
            stateNxt = HZ_RUN;
          end else begin
            cntNxt = cntR - 2'd1;
          end
        end
        default: begin
          stateNxt = HZ_RUN;
          cntNxt   = 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (!pc_write) begin
        stall_count <= stall_count + 32'd1;
      end
      if (branch_taken) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: table-driven vectors on a default
// instance plus hand-written multi-cycle sequences on a LOAD_STALL=3 instance.
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_MemRead, branch_taken;
  logic       pcW, ifW, ifF, cSel;
  logic       pcW3, ifW3, ifF3, cSel3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt, stallCnt3, flushCnt3;
`endif

  always #5 clk = ~clk;

  hazard_detection_unit dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .branch_taken(branch_taken), .pc_write(pcW), .ifid_write(ifW),
    .ifid_flush(ifF), .ctrl_sel(cSel)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stallCnt), .flush_count(flushCnt)
`endif
  );

  hazard_detection_unit #(.LOAD_STALL(3), .FLUSH_CYCLES(2)) dut3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .branch_taken(branch_taken), .pc_write(pcW3), .ifid_write(ifW3),
    .ifid_flush(ifF3), .ctrl_sel(cSel3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stallCnt3), .flush_count(flushCnt3)
`endif
  );

  // Expected output nibbles {pc_write, ifid_write, ifid_flush, ctrl_sel}
  localparam logic [3:0] O_RUN = 4'b1101;
  localparam logic [3:0] O_STL = 4'b0000;
  localparam logic [3:0] O_FLS = 4'b1110;
  localparam logic [3:0] O_RST = 4'b0010;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic [3:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] exp;
    int         which;
  } sb_t;

  vec_t vecs[23];
  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic r, input logic [4:0] a, input logic [4:0] b,
                              input logic u, input logic [4:0] d, input logic m,
                              input logic br, input logic [3:0] e, input string n);
    vec_t v;
    v.rst = r; v.rs1 = a; v.rs2 = b; v.uses = u; v.rd = d; v.mr = m; v.br = br;
    v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses;
    ex_rd = v.rd; ex_MemRead = v.mr; branch_taken = v.br;
  endtask

  // Wait for the mid-cycle sample point, drain the scoreboard, then move past the edge.
  task automatic sampleAll();
    sb_t  e;
    logic [3:0] got;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      got = (e.which == 3) ? {pcW3, ifW3, ifF3, cSel3} : {pcW, ifW, ifF, cSel};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.name, got, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input vec_t v, input int which);
    drive(v);
    sbq.push_back('{name: v.name, exp: v.exp, which: which});
    sampleAll();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic checkCnt(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle, ldUse, brV, rstV;
    idle  = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, O_RUN, "idle");
    ldUse = mk(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, O_STL, "ld_use");
    brV   = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b1, O_FLS, "branch");
    rstV  = mk(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, O_RST, "reset");

    vecs[0]  = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, O_RST, "rst_outputs");
    vecs[1]  = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_RUN, "run_idle");
    vecs[2]  = mk(1'b0, 5'd5, 5'd6, 1'b0, 5'd5, 1'b1, 1'b0, O_STL, "luh_rs1");
    vecs[3]  = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_RUN, "stall_ends");
    vecs[4]  = mk(1'b0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0, O_RUN, "x0_no_hazard");
    vecs[5]  = mk(1'b0, 5'd4, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, O_RUN, "rs2_unused");
    vecs[6]  = mk(1'b0, 5'd4, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, O_STL, "luh_rs2");
    vecs[7]  = mk(1'b0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, O_RUN, "no_memread");
    vecs[8]  = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, O_FLS, "br_flush1");
    vecs[9]  = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_FLS, "br_flush2");
    vecs[10] = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_RUN, "br_done");
    vecs[11] = mk(1'b0, 5'd8, 5'd2, 1'b1, 5'd8, 1'b1, 1'b1, O_FLS, "br_beats_luh");
    vecs[12] = mk(1'b0, 5'd8, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, O_FLS, "flush_ignores_luh");
    vecs[13] = mk(1'b0, 5'd8, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, O_STL, "luh_after_flush");
    vecs[14] = mk(1'b0, 5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, O_STL, "back_to_back_ld");
    vecs[15] = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_RUN, "run_again");
    vecs[16] = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, O_FLS, "br_a");
    vecs[17] = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, O_FLS, "br_restart");
    vecs[18] = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_FLS, "restart_tail");
    vecs[19] = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_RUN, "restart_done");
    vecs[20] = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, O_FLS, "br_before_rst");
    vecs[21] = mk(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_RST, "rst_mid_flush");
    vecs[22] = mk(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, O_RUN, "run_after_rst");

    drive(idle);
    @(posedge clk);
    #1;
    for (int i = 0; i < 23; i++) begin
      step(vecs[i], 1);
    end

    // LOAD_STALL=3: full stall, then a stall aborted by a branch.
    step(rstV, 3);
    ldUse.name = "ls3_c1"; step(ldUse, 3);
    idle.exp = O_STL; idle.name = "ls3_c2"; step(idle, 3);
    idle.name = "ls3_c3"; step(idle, 3);
    idle.exp = O_RUN; idle.name = "ls3_done"; step(idle, 3);
    ldUse.name = "abort_c1"; step(ldUse, 3);
    brV.name = "abort_c2_br"; step(brV, 3);
    idle.exp = O_FLS; idle.name = "abort_c3"; step(idle, 3);
    idle.exp = O_RUN; idle.name = "abort_c4_run"; step(idle, 3);

`ifdef HAZARD_PERF_CNT_EN
    step(brV, 1);
    step(rstV, 1);
    idle.name = "perf_after_rst"; step(idle, 1);
    checkCnt("stall_cnt_reset", stallCnt, 32'd0);
    checkCnt("flush_cnt_reset", flushCnt, 32'd0);
    for (int k = 0; k < 3; k++) begin
      ldUse.name = "perf_ld"; step(ldUse, 1);
      idle.name  = "perf_gap"; step(idle, 1);
    end
    for (int k = 0; k < 2; k++) begin
      brV.name = "perf_br"; step(brV, 1);
      idle.exp = O_FLS; idle.name = "perf_fl2"; step(idle, 1);
      idle.exp = O_RUN; idle.name = "perf_run"; step(idle, 1);
    end
    checkCnt("stall_count", stallCnt, 32'd3);
    checkCnt("flush_count", flushCnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline hazard controller for the 5-stage core; sits in ID, directly upstream of the control-bubble mux and the ID/EX register. It detects load-use hazards and taken branches, and drives four signals: `pc_write`, `ifid_write`, `ifid_flush`, and `ctrl_sel`, the select of the downstream bubble mux (1 = pass control, 0 = zero control). A small FSM holds stalls for multi-cycle loads and holds flushes for a configurable branch penalty.

## Interface
- `LOAD_STALL`, default 1: bubble cycles inserted per load-use hazard (1..4).
- `FLUSH_CYCLES`, default 2: cycles of IF/ID flush plus bubble after a taken branch (1..4).
- `clk  in  1`: core clock. Everything is sampled on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `id_rs1  in  5`: rs1 of the instruction in ID.
- `id_rs2  in  5`: rs2 of the instruction in ID.
- `id_uses_rs2  in  1`: the ID instruction reads rs2 (R/S/B types).
- `ex_rd  in  5`: destination register of the instruction in EX.
- `ex_MemRead  in  1`: the EX instruction is a load.
- `branch_taken  in  1`: branch resolved taken. This is a one-cycle pulse.
- `pc_write  out  1`: PC update enable.
- `ifid_write  out  1`: IF/ID register enable.
- `ifid_flush  out  1`: clears IF/ID to a NOP.
- `ctrl_sel  out  1`: bubble-mux select. 0 inserts a bubble.
- `stall_count  out  32`: cycles spent stalling. Present only with the perf macro.
- `flush_count  out  32`: taken branches seen. Present only with the perf macro.

## Operation
- Hazard term `luh` = `ex_MemRead` && `ex_rd` != 0 && (`ex_rd` == `id_rs1` || (`id_uses_rs2` && `ex_rd` == `id_rs2`)).
- States and outputs:
  - RUN: `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `ctrl_sel`=1, unless a hazard or branch applies this cycle.
  - STALL: `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `ctrl_sel`=0.
  - FLUSH: `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `ctrl_sel`=0.
- `cnt` is a 2-bit down-counter of remaining cycles.
- RUN + `branch_taken`:
  - Outputs take FLUSH values combinationally in the same cycle.
  - If FLUSH_CYCLES > 1: next state FLUSH, `cnt` = FLUSH_CYCLES-2.
- RUN + `luh` (no branch):
  - Outputs take STALL values combinationally in the same cycle.
  - If LOAD_STALL > 1: next state STALL, `cnt` = LOAD_STALL-2.
- STALL / FLUSH: hold their outputs. When `cnt` == 0, go to RUN; otherwise decrement `cnt`.
- Priority: `branch_taken` beats `luh` and beats STALL. A branch while in STALL aborts the stall and enters the flush sequence from its first cycle.
- `branch_taken` while in FLUSH restarts the flush count.
- `luh` re-evaluates every cycle in RUN. Back-to-back dependent loads stall again.
- `rd` = x0 never causes a hazard.

## Timing
- Reset: state RUN, `cnt`=0, counters 0.
- While `reset` is high, outputs are forced to `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `ctrl_sel`=0.
- Reset mid-STALL or mid-FLUSH aborts to RUN on the next edge.
- Detection-to-output latency is zero cycles (combinational from inputs and state). Registers update on the next edge.
- A load-use hazard costs exactly LOAD_STALL bubbles. A taken branch costs exactly FLUSH_CYCLES bubbles.
- There is no combinational path from the outputs back to the inputs.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_count` increments every cycle `pc_write`=0 outside reset.
  - `flush_count` increments on every `branch_taken` cycle.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Not defined: both counter ports and their logic are absent.

## Structure
- Shared package `hazard_pkg` holds:
  - the state enum (`HZ_RUN`, `HZ_STALL`, `HZ_FLUSH`);
  - `REG_ADDR_W`=5;
  - the default LOAD_STALL and FLUSH_CYCLES values.
- One sub-module, `hazard_compare`: the combinational `luh` comparator, reused by the forwarding unit's x0-filtered compare.

## Test plan
- `ex_MemRead`=1, `ex_rd`=5, `id_rs1`=5, defaults → one cycle of `pc_write`=`ifid_write`=`ctrl_sel`=0, then RUN.
- `ex_MemRead`=1, `ex_rd`=0, `id_rs1`=0 → no stall. Also `ex_rd`=7=`id_rs2` with `id_uses_rs2`=0 → no stall.
- `branch_taken` pulse, FLUSH_CYCLES=2 → two consecutive cycles with `ifid_flush`=1, `ctrl_sel`=0, `pc_write`=1.
- LOAD_STALL=3 with `branch_taken` on the second stall cycle → stall aborts; two flush cycles follow; back in RUN after 4 total cycles.
- Reset asserted in the middle of FLUSH → the next cycle is RUN with normal outputs once `reset` is low. With `HAZARD_PERF_CNT_EN`, both counters read 0.
- With `HAZARD_PERF_CNT_EN`: 3 load-use stalls and 2 branches → `stall_count`=3, `flush_count`=2.
